mdu_sequencer: RTL and testbench
================================

Name: mdu_sequencer

Overview:
- Iterative multiply/divide sequencer that owns the HI/LO register pair for MULT, MULTU, DIV, DIVU, MFHI, MFLO, MTHI and MTLO.
- Sits beside the EX-stage ALU. The control decoder issues a start pulse with an op code.
- The block runs a shift-add multiply or a restoring divide over WIDTH cycles.
- It raises stall to the hazard logic whenever the pipeline touches HI/LO or issues a new op while an operation is in flight.

Parameters:
- WIDTH, 32: operand and HI/LO width; iteration count equals WIDTH.
- DIV0_LO, all ones (WIDTH bits): LO value written on divide-by-zero.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  issue request, sampled at rising edge
- op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- rs_val  in  WIDTH  multiplicand / dividend
- rt_val  in  WIDTH  multiplier / divisor
- hi_we  in  1  MTHI write enable
- lo_we  in  1  MTLO write enable
- wdata  in  WIDTH  MTHI/MTLO data
- mf_req  in  1  MFHI/MFLO in EX this cycle
- cancel  in  1  exception flush; aborts an in-flight op
- busy  out  1  operation in flight
- done  out  1  one-cycle pulse; hi/lo hold the new result
- stall  out  1  combinational: busy & (mf_req | start | hi_we | lo_we)
- hi  out  WIDTH  HI register
- lo  out  WIDTH  LO register

Behaviour:
- Reset: async on rst_n low. Outputs: state IDLE, busy=0, done=0, hi=0, lo=0. Internal: count=0, accumulators=0.
- Reset asserted mid-operation discards the operation; no done is produced.

States and transitions:
- IDLE, start=1: latch the op and the sign flags of rs/rt (signed ops only). Load operand magnitudes, set count=0.
  - Next state is CALC, or SIGN directly for DIV/DIVU with rt_val==0.
- CALC: one iteration per cycle; count increments each cycle. After iteration WIDTH-1, go to SIGN.
- SIGN: apply sign correction, write hi/lo, pulse done, return to IDLE.

Latency:
- start sampled at edge T: busy=1 from after edge T until edge T+WIDTH+1.
- done=1 and the new hi/lo are visible in the cycle after edge T+WIDTH+1 (34 cycles for WIDTH=32).
- Divide-by-zero: done follows edge T+1.

Multiply:
- Unsigned 2*WIDTH shift-add product of the magnitudes.
- MULT negates the product when sign_rs ^ sign_rt.
- hi = upper WIDTH bits, lo = lower WIDTH bits.

Divide:
- Restoring divide on the magnitudes.
- DIV: quotient is negated if sign_rs ^ sign_rt; remainder takes the sign of the dividend.
- lo = quotient, hi = remainder.
- Most-negative / -1 yields lo = most-negative, hi = 0; no trap.

Divide-by-zero:
- lo = DIV0_LO, hi = rs_val as latched.

Priority and boundary rules:
- start while busy: ignored; stall is asserted so the pipeline re-presents it after done.
- start together with hi_we/lo_we in IDLE: start wins and the write is dropped.
- hi_we/lo_we in IDLE with no start: the register updates at the edge. hi_we and lo_we may both be set together.
- hi_we/lo_we while busy: ignored; stall is asserted.
- mf_req while busy: stall=1. In the done cycle stall=0 and hi/lo already hold the result, so no bypass is needed.
- cancel in CALC or SIGN: return to IDLE at the next edge with hi/lo unchanged, no done, busy=0.
- cancel in IDLE: no effect; a simultaneous start is still accepted.
- done never asserts in two consecutive cycles.
- Outputs hi/lo change only at SIGN, on an accepted MT write, or on reset.

Test Plan:
- MULT rs=FFFFFFFD (-3), rt=00000007 → at cycle 34 done=1, hi=FFFFFFFF, lo=FFFFFFEB; busy high for exactly 33 cycles.
- MULTU rs=rt=FFFFFFFF → hi=FFFFFFFE, lo=00000001.
- DIVU 100/7 → lo=0000000E, hi=00000002.
- DIV -7/2 → lo=FFFFFFFD, hi=FFFFFFFF.
- DIV 80000000/FFFFFFFF → lo=80000000, hi=0.
- DIV rs=00000055, rt=0 → done 2 cycles after start, lo=FFFFFFFF, hi=00000055.
- Hazards: during a MULT, assert mf_req, hi_we and a second start → stall=1 each cycle, hi/lo unchanged, second start ignored. With mf_req held, stall drops in the done cycle.
- Cancel and reset:
  - cancel at iteration 10 → IDLE next cycle, no done, prior hi/lo intact.
  - rst_n low at iteration 20 → immediate hi=lo=0, busy=0; a new op then completes normally.

Source files
------------

// File: rtl/mdu_sequencer.sv
// Iterative multiply/divide sequencer owning the HI/LO pair.
// Shift-add multiply and restoring divide take one iteration per cycle over WIDTH cycles.
`timescale 1ns/1ps

module mdu_sequencer #(
    parameter int WIDTH = 32,
    parameter logic [WIDTH-1:0] DIV0_LO = '1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    input  logic             mf_req,
    input  logic             cancel,
    output logic             busy,
    output logic             done,
    output logic             stall,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        SIGN = 2'd2
    } state_t;

    state_t           state;
    logic             op_div;
    logic             sign_rs;
    logic             sign_rt;
    logic             div0;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] acc_hi;
    logic [WIDTH-1:0] acc_lo;
    logic [WIDTH-1:0] opnd;

    logic             rs_neg;
    logic             rt_neg;
    logic [WIDTH-1:0] rs_mag;
    logic [WIDTH-1:0] rt_mag;

    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH-1:0]   div_diff;
    logic               div_ok;
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;
    logic [WIDTH-1:0]   res_hi;
    logic [WIDTH-1:0]   res_lo;

    // op[0]=0 selects the signed flavour; unsigned ops never see a sign
    assign rs_neg = ~op[0] & rs_val[WIDTH-1];
    assign rt_neg = ~op[0] & rt_val[WIDTH-1];
    assign rs_mag = rs_neg ? -rs_val : rs_val;
    assign rt_mag = rt_neg ? -rt_val : rt_val;

    // Multiply: acc_lo holds the remaining multiplier bits, product shifts in from the top
    assign mul_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});

    // Divide: acc_hi is the partial remainder, acc_lo shifts dividend out and quotient in
    assign div_shift = {acc_hi, acc_lo[WIDTH-1]};
    assign div_ok    = (div_shift >= {1'b0, opnd});
    assign div_diff  = div_shift[WIDTH-1:0] - opnd;

    assign prod     = {acc_hi, acc_lo};
    assign prod_fix = (sign_rs ^ sign_rt) ? -prod : prod;
    assign quo_fix  = (sign_rs ^ sign_rt) ? -acc_lo : acc_lo;
    assign rem_fix  = sign_rs ? -acc_hi : acc_hi;

    always_comb begin
        res_hi = prod_fix[2*WIDTH-1:WIDTH];
        res_lo = prod_fix[WIDTH-1:0];
        if (op_div) begin
            if (div0) begin
                res_hi = acc_hi;
                res_lo = DIV0_LO;
            end else begin
                res_hi = rem_fix;
                res_lo = quo_fix;
            end
        end
    end

    assign stall = busy & (mf_req | start | hi_we | lo_we);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            hi      <= '0;
            lo      <= '0;
            op_div  <= 1'b0;
            sign_rs <= 1'b0;
            sign_rt <= 1'b0;
            div0    <= 1'b0;
            count   <= '0;
            acc_hi  <= '0;
            acc_lo  <= '0;
            opnd    <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        op_div  <= op[1];
                        sign_rs <= rs_neg;
                        sign_rt <= rt_neg;
                        count   <= '0;
                        busy    <= 1'b1;
                        if (op[1]) begin
                            // Divide-by-zero keeps the raw dividend in acc_hi for HI
                            div0   <= (rt_val == '0);
                            acc_hi <= (rt_val == '0) ? rs_val : '0;
                            acc_lo <= rs_mag;
                            opnd   <= rt_mag;
                            state  <= (rt_val == '0) ? SIGN : CALC;
                        end else begin
                            div0   <= 1'b0;
                            acc_hi <= '0;
                            acc_lo <= rt_mag;
                            opnd   <= rs_mag;
                            state  <= CALC;
                        end
                    end else begin
                        if (hi_we) hi <= wdata;
                        if (lo_we) lo <= wdata;
                    end
                end
                CALC: begin
                    if (cancel) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        if (op_div) begin
                            acc_hi <= div_ok ? div_diff : div_shift[WIDTH-1:0];
                            acc_lo <= {acc_lo[WIDTH-2:0], div_ok};
                        end else begin
                            acc_hi <= mul_sum[WIDTH:1];
                            acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
                        end
                        count <= count + CW'(1);
                        if (count == LAST) state <= SIGN;
                    end
                end
                SIGN: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    if (!cancel) begin
                        hi   <= res_hi;
                        lo   <= res_lo;
                        done <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mdu_sequencer.sv
// Directed self-checking bench for mdu_sequencer: arithmetic results, latency,
// hazard stalls, cancel and asynchronous reset.
`timescale 1ns/1ps

module tb_mdu_sequencer;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] rs_val = '0;
    logic [31:0] rt_val = '0;
    logic        hi_we = 1'b0;
    logic        lo_we = 1'b0;
    logic [31:0] wdata = '0;
    logic        mf_req = 1'b0;
    logic        cancel = 1'b0;
    logic        busy;
    logic        done;
    logic        stall;
    logic [31:0] hi;
    logic [31:0] lo;

    int vectors = 0;
    int miscompares = 0;
    int lat;
    int doneSeen;
    logic [31:0] expHi;
    logic [31:0] expLo;

    mdu_sequencer #(.WIDTH(32), .DIV0_LO(32'hFFFF_FFFF)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .op     (op),
        .rs_val (rs_val),
        .rt_val (rt_val),
        .hi_we  (hi_we),
        .lo_we  (lo_we),
        .wdata  (wdata),
        .mf_req (mf_req),
        .cancel (cancel),
        .busy   (busy),
        .done   (done),
        .stall  (stall),
        .hi     (hi),
        .lo     (lo)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input bit s, input logic [1:0] o, input logic [31:0] a,
                                 input logic [31:0] b, input bit hw, input bit lw,
                                 input logic [31:0] wd, input bit mf, input bit cn);
        start  = s;
        op     = o;
        rs_val = a;
        rt_val = b;
        hi_we  = hw;
        lo_we  = lw;
        wdata  = wd;
        mf_req = mf;
        cancel = cn;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Issue one op, optionally with a colliding MT write or cancel in the start cycle
    task automatic runOp(input string tag, input logic [1:0] o, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el,
                         input int elat, input bit we, input bit cn);
        int busyCycles;
        applyStimulus(1'b1, o, a, b, we, we, 32'hAAAA_5555, 1'b0, cn);
        tick();
        applyStimulus(1'b0, 2'b00, '0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
        checkOutput({tag, " hi held at start"}, hi, expHi);
        checkOutput({tag, " lo held at start"}, lo, expLo);
        busyCycles = 0;
        lat = 0;
        while (!done && lat < 50) begin
            if (busy) busyCycles++;
            tick();
            lat++;
        end
        checkOutput({tag, " latency"}, lat, elat);
        checkOutput({tag, " busy cycles"}, busyCycles, elat);
        checkOutput({tag, " hi"}, hi, eh);
        checkOutput({tag, " lo"}, lo, el);
        checkOutput({tag, " busy in done cycle"}, busy, 1'b0);
        expHi = eh;
        expLo = el;
        tick();
        checkOutput({tag, " single done pulse"}, done, 1'b0);
    endtask

    initial begin
        expHi = '0;
        expLo = '0;
        $display("[TB] reset");
        #3;
        checkOutput("reset busy", busy, 1'b0);
        checkOutput("reset done", done, 1'b0);
        checkOutput("reset hi", hi, 32'h0);
        checkOutput("reset lo", lo, 32'h0);
        tick();
        rst_n = 1'b1;
        tick();

        $display("[TB] MTHI/MTLO writes");
        applyStimulus(1'b0, 2'b00, '0, '0, 1'b1, 1'b1, 32'h1234_5678, 1'b0, 1'b0);
        tick();
        checkOutput("mt both hi", hi, 32'h1234_5678);
        checkOutput("mt both lo", lo, 32'h1234_5678);
        applyStimulus(1'b0, 2'b00, '0, '0, 1'b1, 1'b0, 32'h1111_1111, 1'b0, 1'b0);
        tick();
        checkOutput("mthi hi", hi, 32'h1111_1111);
        checkOutput("mthi lo", lo, 32'h1234_5678);
        applyStimulus(1'b0, 2'b00, '0, '0, 1'b0, 1'b1, 32'h2222_2222, 1'b0, 1'b0);
        tick();
        checkOutput("mtlo hi", hi, 32'h1111_1111);
        checkOutput("mtlo lo", lo, 32'h2222_2222);
        applyStimulus(1'b0, 2'b00, '0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
        expHi = 32'h1111_1111;
        expLo = 32'h2222_2222;

        $display("[TB] arithmetic");
        runOp("mult -3*7", OP_MULT, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 33, 1'b0, 1'b0);
        runOp("mult -2*-3", OP_MULT, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'h0, 32'h6, 33, 1'b0, 1'b0);
        runOp("multu max*max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 33, 1'b0, 1'b0);
        runOp("multu 2^31*2", OP_MULTU, 32'h8000_0000, 32'h0000_0002, 32'h1, 32'h0, 33, 1'b0, 1'b0);
        runOp("divu 100/7", OP_DIVU, 32'd100, 32'd7, 32'h2, 32'hE, 33, 1'b0, 1'b0);
        runOp("div -7/2", OP_DIV, 32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 33, 1'b0, 1'b0);
        runOp("div 7/-2", OP_DIV, 32'h7, 32'hFFFF_FFFE, 32'h1, 32'hFFFF_FFFD, 33, 1'b0, 1'b0);
        runOp("div minneg/-1", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 33, 1'b0, 1'b0);
        runOp("div 55/0", OP_DIV, 32'h55, 32'h0, 32'h55, 32'hFFFF_FFFF, 1, 1'b0, 1'b0);

        $display("[TB] start beats MT write, cancel in idle ignored");
        runOp("multu 3*4 with mt", OP_MULTU, 32'h3, 32'h4, 32'h0, 32'hC, 33, 1'b1, 1'b0);
        runOp("divu with idle cancel", OP_DIVU, 32'hFFFF_FFFF, 32'h10, 32'hF, 32'h0FFF_FFFF, 33, 1'b0, 1'b1);

        $display("[TB] hazards while busy");
        applyStimulus(1'b1, OP_MULT, 32'd5, 32'd6, 1'b0, 1'b0, '0, 1'b0, 1'b0);
        tick();
        lat = 0;
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, OP_MULTU, 32'h1, 32'h1, 1'b1, 1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0);
            #1;
            checkOutput("hazard stall", stall, 1'b1);
            tick();
            lat++;
            checkOutput("hazard hi held", hi, expHi);
            checkOutput("hazard lo held", lo, expLo);
        end
        applyStimulus(1'b0, 2'b00, '0, '0, 1'b0, 1'b0, '0, 1'b1, 1'b0);
        #1;
        checkOutput("mf stall", stall, 1'b1);
        while (!done && lat < 50) begin
            tick();
            lat++;
        end
        checkOutput("hazard latency", lat, 33);
        checkOutput("mf stall in done cycle", stall, 1'b0);
        checkOutput("hazard result hi", hi, 32'h0);
        checkOutput("hazard result lo", lo, 32'h1E);
        applyStimulus(1'b0, 2'b00, '0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
        tick();
        checkOutput("second start ignored", busy, 1'b0);
        expHi = 32'h0;
        expLo = 32'h1E;

        $display("[TB] cancel mid-operation");
        applyStimulus(1'b1, OP_MULT, 32'd9, 32'd9, 1'b0, 1'b0, '0, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b0, 2'b00, '0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) tick();
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        checkOutput("cancel busy", busy, 1'b0);
        checkOutput("cancel done", done, 1'b0);
        doneSeen = 0;
        for (int i = 0; i < 40; i++) begin
            if (done) doneSeen++;
            tick();
        end
        checkOutput("cancel no done", doneSeen, 0);
        checkOutput("cancel hi intact", hi, expHi);
        checkOutput("cancel lo intact", lo, expLo);

        $display("[TB] reset mid-operation");
        applyStimulus(1'b1, OP_MULTU, 32'h7, 32'h7, 1'b0, 1'b0, '0, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b0, 2'b00, '0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) tick();
        rst_n = 1'b0;
        #1;
        checkOutput("midreset busy", busy, 1'b0);
        checkOutput("midreset hi", hi, 32'h0);
        checkOutput("midreset lo", lo, 32'h0);
        tick();
        rst_n = 1'b1;
        checkOutput("midreset no done", done, 1'b0);
        tick();
        expHi = 32'h0;
        expLo = 32'h0;
        runOp("multu after reset", OP_MULTU, 32'h0001_0000, 32'h0001_0000, 32'h1, 32'h0, 33, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
